// File: rtl/step_scheduler.sv
// step_scheduler: turns manual button presses and frame-paced automatic
// requests into single step requests for the robot world. At most one step
// is issued per video frame, and each step is issued only during vertical
// blank. Every request is either acknowledged or ends in a timeout.
module step_scheduler #(
  parameter int V_ACTIVE        = 480,
  parameter int FRAMES_PER_STEP = 30,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACK_TIMEOUT     = 1024
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic [9:0]  pixel_y,
  input  logic        key_step_n,
  input  logic        auto_en,
  input  logic        pause,
  input  logic        step_ack,
  output logic        step_req,
  output logic        frame_tick,
  output logic        pending,
  output logic        ack_err,
  output logic [15:0] step_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_CLR = 2'd2
  } state_t;

  localparam logic [9:0]  V_LIMIT  = 10'(V_ACTIVE);
  localparam logic [7:0]  FPS_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

  logic        key_meta;
  logic        key_sync;
  logic        key_db;
  logic        key_db_q;
  logic [19:0] db_cnt;
  logic [9:0]  py_prev;
  logic [7:0]  frame_cnt;
  logic        issued;
  logic [15:0] ack_timer;
  state_t      state;

  logic        in_vblank;
  logic        vb_entry;
  logic        man_req;
  logic        auto_req;
  logic        issue;

  // Request sources and the issue condition.
  // NOTE: every signal driven here gets a value on every path through the
  // block, otherwise synthesis has to infer a latch to hold the old value.
  always_comb begin
    in_vblank = (pixel_y >= V_LIMIT);
    vb_entry  = (py_prev < V_LIMIT) && in_vblank;
    man_req   = key_db_q && !key_db;
    auto_req  = frame_tick && auto_en && !pause && (frame_cnt == FPS_LAST);
    // A step is issued only once frame_tick has cleared the issued flag for
    // this frame, so the vblank-entry cycle and the tick cycle itself wait.
    // That also lets an auto request raised on the tick merge into a manual
    // request already pending.
    issue     = (state == S_IDLE) && pending && in_vblank && !issued &&
                !frame_tick && !vb_entry;
  end

  // Two-flop synchronizer for the asynchronous push button; idles high.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, whatever order the statements are in.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_step_n;
      key_sync <= key_meta;
    end
  end

  // Debouncer: the output follows the input only after it has held a new
  // value for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
      db_cnt   <= '0;
    end else begin
      key_db_q <= key_db;
      if (key_sync == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end
    end
  end

  // Vblank-entry detector: one registered pulse per crossing of V_ACTIVE.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      py_prev    <= '0;
      frame_tick <= 1'b0;
    end else begin
      py_prev    <= pixel_y;
      frame_tick <= vb_entry;
    end
  end

  // Frame counter for automatic stepping; held at zero while disabled and
  // frozen while paused.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else if (!auto_en) begin
      frame_cnt <= '0;
    end else if (frame_tick && !pause) begin
      frame_cnt <= (frame_cnt == FPS_LAST) ? 8'd0 : frame_cnt + 8'd1;
    end
  end

  // Single-entry request queue plus the once-per-frame issued flag. A request
  // that arrives on the issue cycle stays pending for the next frame.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      issued  <= 1'b0;
    end else begin
      pending <= (pending && !issue) || man_req || auto_req;
      if (issue) begin
        issued <= 1'b1;
      end else if (frame_tick) begin
        issued <= 1'b0;
      end
    end
  end

  // Request handshake FSM with acknowledge timeout; outputs are registered.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      step_req   <= 1'b0;
      ack_err    <= 1'b0;
      step_count <= '0;
      ack_timer  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            state     <= S_REQ;
            step_req  <= 1'b1;
            ack_timer <= '0;
          end
        end
        S_REQ: begin
          if (step_ack) begin
            state      <= S_WAIT_CLR;
            step_req   <= 1'b0;
            step_count <= step_count + 16'd1;
          end else if (ack_timer == ACK_LAST) begin
            state    <= S_WAIT_CLR;
            step_req <= 1'b0;
            ack_err  <= 1'b1;
          end else begin
            ack_timer <= ack_timer + 16'd1;
          end
        end
        S_WAIT_CLR: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          step_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: directed scenarios push the expected step_count
// at issue time into a queue; a monitor pops an entry on every rising
// step_req and compares.
module tb_step_scheduler;

  logic        clk;
  logic        reset_n;
  logic [9:0]  pixel_y;
  logic        key_step_n;
  logic        auto_en;
  logic        pause;
  logic        step_ack;
  logic        step_req;
  logic        frame_tick;
  logic        pending;
  logic        ack_err;
  logic [15:0] step_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  bit ack_en    = 1'b1;
  int ack_delay = 1;

  step_scheduler #(
    .V_ACTIVE        (480),
    .FRAMES_PER_STEP (3),
    .DEBOUNCE_CYCLES (4),
    .ACK_TIMEOUT     (8)
  ) dut (
    .CLOCK_50   (clk),
    .reset_n    (reset_n),
    .pixel_y    (pixel_y),
    .key_step_n (key_step_n),
    .auto_en    (auto_en),
    .pause      (pause),
    .step_ack   (step_ack),
    .step_req   (step_req),
    .frame_tick (frame_tick),
    .pending    (pending),
    .ack_err    (ack_err),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One video frame: act cycles of active video then vb cycles of vblank.
  task automatic frame(input int act, input int vb, output int ft);
    ft = 0;
    pixel_y = 10'd100;
    repeat (act) begin
      tick(1);
      if (frame_tick) ft++;
    end
    pixel_y = 10'd480;
    repeat (vb) begin
      tick(1);
      if (frame_tick) ft++;
    end
  endtask

  task automatic press(input int low_cycles);
    key_step_n = 1'b0;
    tick(low_cycles);
    key_step_n = 1'b1;
    tick(10);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    pixel_y = 10'd100;
    key_step_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  // Robot-world model: pulse step_ack ack_delay cycles into each request.
  initial begin
    int  req_cycles;
    bit  sent;
    req_cycles = 0;
    sent = 1'b0;
    step_ack = 1'b0;
    forever begin
      @(negedge clk);
      step_ack = 1'b0;
      if (step_req && ack_en && !sent) begin
        req_cycles++;
        if (req_cycles >= ack_delay) begin
          step_ack = 1'b1;
          sent = 1'b1;
        end
      end
      if (!step_req) begin
        req_cycles = 0;
        sent = 1'b0;
      end
    end
  end

  // Monitor: every new request is matched against the scoreboard.
  initial begin
    bit prev;
    int e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (step_req && !prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step_req", 32'(step_count), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("step_count_at_issue", 32'(step_count), 32'(e));
        end
      end
      prev = step_req;
    end
  end

  initial begin
    int ft;
    int hi;
    bit seen;

    reset_n    = 1'b0;
    pixel_y    = 10'd480;
    key_step_n = 1'b1;
    auto_en    = 1'b0;
    pause      = 1'b0;
    tick(3);
    check("rst_step_req",   32'(step_req),   32'd0);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check("rst_pending",    32'(pending),    32'd0);
    check("rst_ack_err",    32'(ack_err),    32'd0);
    check("rst_step_count", 32'(step_count), 32'd0);
    pixel_y = 10'd100;
    reset_n = 1'b1;
    tick(3);

    // Manual press during active video waits for vblank, ack after 2 cycles.
    ack_delay = 2;
    press(10);
    check("man_pending_active", 32'(pending),  32'd1);
    check("man_no_req_active",  32'(step_req), 32'd0);
    exp_q.push_back(0);
    pixel_y = 10'd480;
    tick(12);
    check("man_step_count", 32'(step_count), 32'd1);
    check("man_pending_clr", 32'(pending),   32'd0);

    // A 3-cycle glitch is shorter than the debounce window.
    pixel_y = 10'd100;
    tick(3);
    press(3);
    tick(5);
    check("glitch_pending", 32'(pending), 32'd0);
    frame(10, 12, ft);
    check("glitch_step_count", 32'(step_count), 32'd1);

    // Automatic stepping every third frame: 9 frames give 3 steps.
    apply_reset();
    ack_delay = 1;
    auto_en = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    frame(10, 12, ft);
    check("frame_tick_one_cycle", 32'(ft), 32'd1);
    repeat (8) frame(10, 12, ft);
    check("auto_9_frames", 32'(step_count), 32'd3);

    // Same with pause held for the first 3 frames: only 2 steps.
    apply_reset();
    pause = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    repeat (3) frame(10, 12, ft);
    check("paused_no_steps", 32'(step_count), 32'd0);
    pause = 1'b0;
    repeat (6) frame(10, 12, ft);
    check("auto_paused_9_frames", 32'(step_count), 32'd2);

    // Manual press and auto request inside one frame merge into one step.
    apply_reset();
    frame(10, 12, ft);
    frame(10, 12, ft);
    pixel_y = 10'd100;
    press(10);
    check("merge_pending", 32'(pending), 32'd1);
    exp_q.push_back(0);
    pixel_y = 10'd480;
    tick(12);
    check("merge_step_count", 32'(step_count), 32'd1);
    check("merge_pending_clr", 32'(pending),   32'd0);

    // Second press in the same frame is held until the next vblank.
    auto_en = 1'b0;
    pixel_y = 10'd100;
    tick(2);
    press(10);
    exp_q.push_back(1);
    pixel_y = 10'd480;
    tick(12);
    check("two_press_first", 32'(step_count), 32'd2);
    press(10);
    check("two_press_held_pending", 32'(pending),    32'd1);
    check("two_press_held_count",   32'(step_count), 32'd2);
    exp_q.push_back(2);
    frame(10, 12, ft);
    check("two_press_second", 32'(step_count), 32'd3);
    check("two_press_pending_clr", 32'(pending), 32'd0);

    // No acknowledge: request held for ACK_TIMEOUT cycles, then error.
    apply_reset();
    ack_en = 1'b0;
    press(10);
    exp_q.push_back(0);
    pixel_y = 10'd480;
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (step_req) hi++;
    end
    tick(1);
    check("timeout_req_cycles", 32'(hi),         32'd8);
    check("timeout_ack_err",    32'(ack_err),    32'd1);
    check("timeout_step_count", 32'(step_count), 32'd0);
    check("timeout_pending",    32'(pending),    32'd0);
    apply_reset();
    check("timeout_err_cleared", 32'(ack_err), 32'd0);

    // Reset asserted mid-request drops step_req asynchronously.
    press(10);
    exp_q.push_back(0);
    pixel_y = 10'd480;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (step_req) seen = 1'b1;
    end
    check("abort_req_seen", 32'(seen), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_step_req",   32'(step_req),   32'd0);
    check("abort_step_count", 32'(step_count), 32'd0);
    check("abort_pending",    32'(pending),    32'd0);
    tick(2);
    pixel_y = 10'd100;
    reset_n = 1'b1;
    tick(4);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
